instr_fetch: RTL
================

Name: instr_fetch

Overview:
Fetch unit that drives the instruction memory and hands fetched instructions to decode.
- Generates the PC for the synchronous-read instruction memory (1-cycle read latency, word index pc[11:2], no read enable) and tracks in-flight reads.
- Buffers returned instructions in a small FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes wrong-path work.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, fetch buffer entries (power of 2, >=2); 4 sustains 1 instr/cycle

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset); top ties instruction memory reset to ~reset
fetch_en  input  1  1 = new fetches may issue
imem_pc  output  32  address to instruction memory (registered)
imem_instr  input  32  memory read data, valid one cycle after imem_pc presented
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  redirect target; bits [1:0] forced to 0
out_valid  output  1  fetch entry available
out_ready  input  1  decode accepts entry
out_pc  output  32  PC of head entry
out_instr  output  32  instruction of head entry

Behaviour:
- Reset (async, immediate, no clock needed): fetch_pc=RESET_PC (so imem_pc=RESET_PC), inflight_q=0, FIFO empty, out_valid=0, out_pc=0, out_instr=0.
- imem_pc = fetch_pc register.
- Issue condition each cycle: fetch_en=1 and redirect_valid=0 and (fifo_count + inflight_q) < FIFO_DEPTH. Pop does not give credit.
- On issue:
  - inflight_q<=1, inflight_pc_q<=fetch_pc, fetch_pc<=fetch_pc+4.
  - 32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000. Address aliasing above 4 KB is the memory's concern.
- No issue: fetch_pc holds, inflight_q<=0.
- Return: when inflight_q=1 and redirect_valid=0, push {inflight_pc_q, imem_instr} into FIFO at that edge. Overflow is impossible by the issue rule; assertion required.
- Output: out_valid = FIFO non-empty and redirect_valid=0.
  - out_pc/out_instr = head entry when out_valid=1, else 0.
  - Pop when out_valid and out_ready.
- Redirect (redirect_valid=1 in cycle T):
  - FIFO flushed, inflight_q<=0 (in-flight data discarded, not pushed), fetch_pc<={redirect_pc[31:2],2'b00}.
  - No pop in cycle T even if out_ready=1.
  - Redirect wins over issue, push and pop in the same cycle.
  - Back-to-back redirects: last one wins.
  - Redirect while fetch_en=0 still updates fetch_pc.
- Latency:
  - Reset release at edge E: first out_valid 2 cycles after E, out_pc=RESET_PC.
  - Redirect in T: imem_pc=target during T+1, entry pushed at end of T+2, out_valid in T+3.
- Throughput: one entry/cycle steady state with FIFO_DEPTH>=4 and out_ready=1.
- Backpressure: FIFO fills to FIFO_DEPTH, fetch_pc stops; no entry lost, duplicated or reordered.
- fetch_en deassert: issue stops next cycle; in-flight read still pushed; FIFO drains normally.
- Memory output during reset is ignored because inflight_q=0.

Decomposition:
- Package riscv_pkg:
  - XLEN=32, INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h0000_0013.
  - typedef struct packed fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with DEPTH parameter.
  - Ports: push, pop, flush (flush highest priority), count, empty, full, head.
  - Same clk and active-low async reset.
- Top handles PC register, in-flight tracking, issue and redirect logic.

Test Plan:
- Reset release, mem[0]=0x00500093, mem[1]=0x00A00113, out_ready=1 -> out_valid 2 cycles after release; (pc 0x0, 0x00500093) then (0x4, 0x00A00113) on consecutive cycles.
- out_ready=0 for 10 cycles from start -> FIFO holds 4 entries, imem_pc stalls at 0x10; raise out_ready -> pcs 0x0, 0x4, 0x8, 0xC, 0x10 in order, no gaps.
- Redirect to 0x100 with 3 entries buffered and out_ready=1 -> no pop that cycle, out_valid=0 for cycles T..T+2, first entry in T+3 is pc 0x100 = mem[64].
- Redirect with redirect_pc=0x103 -> imem_pc=0x100 next cycle, out_pc=0x100.
- Async reset asserted mid-stream between clock edges -> out_valid=0 and imem_pc=RESET_PC immediately; after release, fetch restarts at RESET_PC with no stale entries.
- fetch_en=0 with 2 entries buffered -> both delivered, then out_valid stays 0; redirect to 0x40 while disabled, then fetch_en=1 -> first out_pc 0x40.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-path types and constants used by the fetch unit and its buffer.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush overrides push and pop in the same cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [AW:0]  count,
    output logic         empty,
    output logic         full,
    output fetch_entry_t head
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && !flush && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: PC generation for a 1-cycle synchronous imem, in-flight tracking,
// fetch buffering and redirect handling toward decode.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic [XLEN-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            issue, push, pop;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full;
    fetch_entry_t    head, push_data;

    assign imem_pc = fetch_pc_q;

    always_comb begin
        // Credit counts the read already in flight; a pop this cycle gives none
        issue      = fetch_en && !redirect_valid &&
                     ((fifo_count + CW'(inflight_q)) < CW'(FIFO_DEPTH));
        push       = inflight_q && !redirect_valid;
        out_valid  = !fifo_empty && !redirect_valid;
        pop        = out_valid && out_ready;
        push_data  = '{pc: inflight_pc_q, instr: imem_instr};
        out_pc     = out_valid ? head.pc : '0;
        out_instr  = out_valid ? head.instr : '0;

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_STEP;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head      (head)
    );

    // The issue credit rule must make a push into a full buffer impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                    (push |-> !fifo_full));

endmodule
